// File: rtl/sfx_arbiter_pkg.sv
// Shared definitions for the SFX override arbiter: FSM state encodings and
// the positions of the four tone nibbles inside a 16-bit SFX word.
package sfx_arbiter_pkg;

    typedef enum logic [1:0] {
        SA_IDLE = 2'd0,
        SA_PLAY = 2'd1,
        SA_DONE = 2'd2
    } sa_state_e;

    localparam int SFX_W  = 16;
    localparam int TONE_W = 4;

    // Channel 0 lives in the top nibble so the word reads left-to-right as t0..t3.
    localparam int T0_LSB = 12;
    localparam int T1_LSB = 8;
    localparam int T2_LSB = 4;
    localparam int T3_LSB = 0;

    function automatic logic [TONE_W-1:0] tone_of(input logic [SFX_W-1:0] word, input int lsb);
        return word[lsb +: TONE_W];
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Produces a one-cycle pulse three clk cycles after the async input rises.
module pulse_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    // sync_q[0], sync_q[1] are the synchronizer stages; sync_q[2] holds the previous level.
    logic [2:0] sync_q, sync_d;
    logic       pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[1:0], async_in};
        pulse_d = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/sfx_arbiter.sv
// Round-robin owner of the APU tone-override path: grants one requester,
// drives its SFX tones for a number of note ticks, then pulses done.
module sfx_arbiter
    import sfx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DUR_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     note_clk,
    input  logic                     abort,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*16-1:0]    req_sfx,
    input  logic [NUM_REQ*DUR_W-1:0] req_dur,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     active,
    output logic                     done,
    output logic [1:0]               owner,
    output logic [3:0]               ov_t0,
    output logic [3:0]               ov_t1,
    output logic [3:0]               ov_t2,
    output logic [3:0]               ov_t3
);

    logic tick;

    pulse_sync u_note_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (note_clk),
        .pulse    (tick)
    );

    logic [SFX_W-1:0] sfx_arr [NUM_REQ];
    logic [DUR_W-1:0] dur_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign sfx_arr[gi] = req_sfx[SFX_W*gi +: SFX_W];
        assign dur_arr[gi] = req_dur[DUR_W*gi +: DUR_W];
    end

    // First set bit at or after ptr, wrapping; ptr itself when nothing is set.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    sa_state_e          state_q, state_d;
    logic [1:0]         rr_q, rr_d;
    logic [1:0]         owner_q, owner_d;
    logic [DUR_W-1:0]   remaining_q, remaining_d;
    logic [SFX_W-1:0]   sfx_q, sfx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               active_q, active_d;
    logic               done_q, done_d;
    logic [1:0]         winner;

    assign winner = rr_pick(req, rr_q);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        remaining_d = remaining_q;
        sfx_d       = sfx_q;
        grant_d     = '0;
        active_d    = active_q;
        done_d      = 1'b0;
        case (state_q)
            SA_IDLE: begin
                // A tick landing on this cycle is deliberately ignored: counting starts in PLAY.
                if (|req) begin
                    grant_d[winner] = 1'b1;
                    owner_d         = winner;
                    rr_d            = winner + 2'd1;
                    sfx_d           = sfx_arr[winner];
                    remaining_d     = (dur_arr[winner] == '0) ? DUR_W'(1) : dur_arr[winner];
                    active_d        = 1'b1;
                    state_d         = SA_PLAY;
                end
            end
            SA_PLAY: begin
                if (abort || (tick && remaining_q == DUR_W'(1))) begin
                    sfx_d    = '0;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = SA_DONE;
                end else if (tick) begin
                    remaining_d = remaining_q - DUR_W'(1);
                end
            end
            SA_DONE: begin
                state_d = SA_IDLE;
            end
            default: begin
                sfx_d    = '0;
                active_d = 1'b0;
                state_d  = SA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SA_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            remaining_q <= '0;
            sfx_q       <= '0;
            grant_q     <= '0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            remaining_q <= remaining_d;
            sfx_q       <= sfx_d;
            grant_q     <= grant_d;
            active_q    <= active_d;
            done_q      <= done_d;
        end
    end

    assign grant  = grant_q;
    assign active = active_q;
    assign done   = done_q;
    assign owner  = owner_q;
    assign ov_t0  = tone_of(sfx_q, T0_LSB);
    assign ov_t1  = tone_of(sfx_q, T1_LSB);
    assign ov_t2  = tone_of(sfx_q, T2_LSB);
    assign ov_t3  = tone_of(sfx_q, T3_LSB);

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed bench for sfx_arbiter: grant/override/done sequencing, round-robin
// order, abort, zero duration, asynchronous reset and tick counting.
module tb_sfx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        note_clk = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] req_sfx = '0;
    logic [31:0] req_dur = '0;
    logic [3:0]  grant;
    logic        active;
    logic        done;
    logic [1:0]  owner;
    logic [3:0]  ov_t0, ov_t1, ov_t2, ov_t3;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    int done_base  = 0;
    int rises      = 0;
    logic [3:0] rr_exp [5];

    sfx_arbiter #(.NUM_REQ(4), .DUR_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .note_clk (note_clk),
        .abort    (abort),
        .req      (req),
        .req_sfx  (req_sfx),
        .req_dur  (req_dur),
        .grant    (grant),
        .active   (active),
        .done     (done),
        .owner    (owner),
        .ov_t0    (ov_t0),
        .ov_t1    (ov_t1),
        .ov_t2    (ov_t2),
        .ov_t3    (ov_t3)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full note_clk period, long enough for the synchronizer to see each level.
    task automatic note_pulse();
        note_clk = 1'b1;
        wait_neg(4);
        note_clk = 1'b0;
        wait_neg(4);
    endtask

    initial begin
        // Reset state
        wait_neg(2);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_ov", 32'({ov_t0, ov_t1, ov_t2, ov_t3}), 32'h0);
        reset = 1'b0;
        wait_neg(2);

        // Single request on requester 1, sfx 1234, dur 3
        req_sfx[16 +: 16] = 16'h1234;
        req_dur[8 +: 8]   = 8'd3;
        req = 4'b0010;
        wait_neg(1);
        $display("single: grant=%b ov=%h%h%h%h", grant, ov_t0, ov_t1, ov_t2, ov_t3);
        chk("single_grant", 32'(grant), 32'h2);
        chk("single_active", 32'(active), 32'h1);
        chk("single_ov", 32'({ov_t0, ov_t1, ov_t2, ov_t3}), 32'h1234);
        chk("single_owner", 32'(owner), 32'h1);
        req = 4'b0000;
        req_sfx[16 +: 16] = 16'hFFFF;
        wait_neg(1);
        chk("single_grant_pulse", 32'(grant), 32'h0);
        note_pulse();
        note_pulse();
        chk("single_mid_active", 32'(active), 32'h1);
        chk("single_mid_ov", 32'({ov_t0, ov_t1, ov_t2, ov_t3}), 32'h1234);
        chk("single_mid_done", 32'(done), 32'h0);
        note_clk = 1'b1;
        wait_neg(4);
        $display("single: done=%b active=%b owner=%0d", done, active, owner);
        chk("single_done", 32'(done), 32'h1);
        chk("single_done_active", 32'(active), 32'h0);
        chk("single_done_ov", 32'({ov_t0, ov_t1, ov_t2, ov_t3}), 32'h0);
        chk("single_done_owner", 32'(owner), 32'h1);
        wait_neg(1);
        chk("single_done_pulse", 32'(done), 32'h0);
        note_clk = 1'b0;
        wait_neg(4);

        // Round-robin from a fresh reset: 0,1,2,3,0
        reset = 1'b1;
        wait_neg(1);
        reset = 1'b0;
        req_sfx = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req_dur = {8'd1, 8'd1, 8'd1, 8'd1};
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        req = 4'b1111;
        wait_neg(1);
        for (int i = 0; i < 5; i++) begin
            $display("rr[%0d]: grant=%b owner=%0d", i, grant, owner);
            chk($sformatf("rr_grant%0d", i), 32'(grant), 32'(rr_exp[i]));
            if (i == 4) req = 4'b0000;
            note_clk = 1'b1;
            wait_neg(4);
            chk($sformatf("rr_done%0d", i), 32'(done), 32'h1);
            note_clk = 1'b0;
            wait_neg(1);
            chk($sformatf("rr_gap%0d", i), 32'(grant), 32'h0);
            wait_neg(1);
        end
        wait_neg(4);

        // Abort: rr now 1, only requester 0 asks
        req_sfx[0 +: 16] = 16'hF00F;
        req_dur[0 +: 8]  = 8'd10;
        req = 4'b0001;
        wait_neg(1);
        $display("abort: grant=%b ov=%h%h%h%h", grant, ov_t0, ov_t1, ov_t2, ov_t3);
        chk("abort_grant", 32'(grant), 32'h1);
        chk("abort_ov", 32'({ov_t0, ov_t1, ov_t2, ov_t3}), 32'hF00F);
        req = 4'b0000;
        note_pulse();
        note_pulse();
        chk("abort_pre_active", 32'(active), 32'h1);
        abort = 1'b1;
        wait_neg(1);
        abort = 1'b0;
        $display("abort: done=%b ov_t0=%h ov_t3=%h", done, ov_t0, ov_t3);
        chk("abort_done", 32'(done), 32'h1);
        chk("abort_ov_t0", 32'(ov_t0), 32'h0);
        chk("abort_ov_t3", 32'(ov_t3), 32'h0);
        chk("abort_active", 32'(active), 32'h0);
        abort = 1'b1;
        wait_neg(5);
        abort = 1'b0;
        chk("abort_no_grant", 32'(grant), 32'h0);
        chk("abort_idle_active", 32'(active), 32'h0);

        // Zero duration with a tick landing on the grant cycle
        req_sfx[32 +: 16] = 16'h5678;
        req_dur[16 +: 8]  = 8'd0;
        note_clk = 1'b1;
        wait_neg(3);
        req = 4'b0100;
        wait_neg(1);
        req = 4'b0000;
        $display("dur0: grant=%b active=%b", grant, active);
        chk("dur0_grant", 32'(grant), 32'h4);
        chk("dur0_ov", 32'({ov_t0, ov_t1, ov_t2, ov_t3}), 32'h5678);
        wait_neg(1);
        chk("dur0_not_counted", 32'(done), 32'h0);
        chk("dur0_still_active", 32'(active), 32'h1);
        note_clk = 1'b0;
        wait_neg(4);
        chk("dur0_hold_active", 32'(active), 32'h1);
        note_clk = 1'b1;
        wait_neg(4);
        chk("dur0_done", 32'(done), 32'h1);
        note_clk = 1'b0;
        wait_neg(4);

        // Reset mid-PLAY: rr was 3, requester 1 gets it, then reset
        req_sfx[16 +: 16] = 16'hABCD;
        req_dur[8 +: 8]   = 8'd5;
        req = 4'b0010;
        wait_neg(1);
        req = 4'b0000;
        chk("rstplay_grant", 32'(grant), 32'h2);
        wait_neg(1);
        reset = 1'b1;
        #1;
        $display("rstplay: active=%b owner=%0d ov=%h%h%h%h", active, owner, ov_t0, ov_t1, ov_t2, ov_t3);
        chk("rstplay_active", 32'(active), 32'h0);
        chk("rstplay_ov", 32'({ov_t0, ov_t1, ov_t2, ov_t3}), 32'h0);
        chk("rstplay_owner", 32'(owner), 32'h0);
        wait_neg(1);
        reset = 1'b0;
        req = 4'b1001;
        wait_neg(1);
        req = 4'b0000;
        chk("rstplay_rr0", 32'(grant), 32'h1);
        abort = 1'b1;
        wait_neg(1);
        abort = 1'b0;
        wait_neg(2);
        req = 4'b1000;
        wait_neg(1);
        req = 4'b0000;
        $display("rstplay: grant=%b owner=%0d", grant, owner);
        chk("rstplay_grant3", 32'(grant), 32'h8);
        chk("rstplay_owner3", 32'(owner), 32'h3);
        abort = 1'b1;
        wait_neg(1);
        abort = 1'b0;
        wait_neg(2);

        // Non-integer note_clk ratio: half-period 17 ns against a 10 ns clk
        req_sfx[0 +: 16] = 16'h0000;
        req_dur[0 +: 8]  = 8'd5;
        req = 4'b0001;
        wait_neg(1);
        req = 4'b0000;
        chk("ratio_grant", 32'(grant), 32'h1);
        chk("ratio_zero_word_active", 32'(active), 32'h1);
        done_base = done_cnt;
        rises = 0;
        for (int h = 0; h < 8; h++) begin
            note_clk = ~note_clk;
            if (note_clk) rises++;
            #17;
        end
        wait_neg(6);
        $display("ratio: rises=%0d active=%b dones=%0d", rises, active, done_cnt - done_base);
        chk("ratio_4_active", 32'(active), 32'h1);
        chk("ratio_4_no_done", 32'(done_cnt - done_base), 32'h0);
        note_clk = 1'b1;
        rises++;
        #17;
        note_clk = 1'b0;
        wait_neg(5);
        $display("ratio: rises=%0d active=%b dones=%0d", rises, active, done_cnt - done_base);
        chk("ratio_5_done", 32'(done_cnt - done_base), 32'h1);
        chk("ratio_5_active", 32'(active), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
